weight_mem_responder: RTL



---
 rtl/weight_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/weight_mem_responder.sv
// Memory-side responder for the weight fetch path: holds the weight store (filled off-chip)
// and serves one 18-word record per level-held request as a single-cycle valid burst.
module weight_mem_responder #(
  parameter int unsigned NUM_RECORDS = 256,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 13
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_addr_i,
  input  logic signed [DATA_W-1:0] wr_data_i,
  output logic                     wr_ready_o,
  input  logic [15:0]              weight_addr_i,
  input  logic                     weight_request_i,
  output logic signed [DATA_W-1:0] weight_data_o [17:0],
  output logic                     weight_valid_o,
  output logic                     busy_o,
  output logic                     addr_err_o
);

  localparam int unsigned WORDS  = 18;
  localparam int unsigned DEPTH  = NUM_RECORDS * WORDS;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned REC_W  = (NUM_RECORDS > 1) ? $clog2(NUM_RECORDS) : 1;
  localparam int unsigned CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] FETCH     = 2'd1;
  localparam logic [1:0] RESPOND   = 2'd2;
  localparam logic [1:0] WAIT_DROP = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [REC_W-1:0]         rec_q, rec_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [DATA_W-1:0] data_q [WORDS-1:0];
  logic signed [DATA_W-1:0] data_d [WORDS-1:0];
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] rd_data_q;
  logic                     req_in_range;
  logic                     mem_we;
  logic                     mem_re;
  logic [MEM_AW-1:0]        rd_addr;

  assign req_in_range = 32'(weight_addr_i) < NUM_RECORDS;
  assign wr_ready_o   = (state_q == IDLE) && !weight_request_i;
  assign mem_we       = wr_en_i && wr_ready_o && !reset && (32'(wr_addr_i) < DEPTH);
  assign mem_re       = (state_q == FETCH) && (cnt_q < LAST_CNT);
  assign rd_addr      = MEM_AW'(rec_q) * MEM_AW'(WORDS) + MEM_AW'(cnt_q);

  // Single-port store: a write and a read never share a cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[MEM_AW'(wr_addr_i)] <= wr_data_i;
    end else if (mem_re) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (weight_request_i) begin
          if (req_in_range) begin
            rec_d   = REC_W'(weight_addr_i);
            cnt_d   = '0;
            state_d = FETCH;
          end else begin
            for (int k = 0; k < int'(WORDS); k++) data_d[k] = '0;
            err_d   = 1'b1;
            state_d = RESPOND;
          end
        end
      end
      FETCH: begin
        // Read data lags the address by one cycle, so slot cnt-1 lands now.
        if (cnt_q != '0) data_d[cnt_q - CNT_W'(1)] = rd_data_q;
        if (cnt_q == LAST_CNT) state_d = RESPOND;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      RESPOND:   state_d = WAIT_DROP;
      WAIT_DROP: if (!weight_request_i) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    valid_d = (state_d == RESPOND);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rec_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < int'(WORDS); k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign weight_data_o  = data_q;
  assign weight_valid_o = valid_q;
  assign addr_err_o     = err_q;
  assign busy_o         = busy_q;

endmodule
